sin_cos_cordic: RTL and testbench
=================================

# sin_cos_cordic

Iterative fixed-point CORDIC engine that computes sine or cosine of a normalized angle. It sits directly downstream of the code decoder. The decoder supplies the angle, the sine/cosine select and a one-cycle start pulse. The block returns the registered result on its value output, with a done pulse and a busy flag. One micro-rotation is performed per clock, so area stays small at the cost of latency.

## Interface
- DATA_WIDTH, 32: width of the angle and result words. Fixed-point format is signed Q2.30; only 32 is supported.
- ITERATIONS, 24: number of CORDIC micro-rotations. Legal range is 1..30.
- COUNT_WIDTH, 5: width of the iteration counter. Must satisfy 2^COUNT_WIDTH > ITERATIONS.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sin_calc_start  in  1  start request; sampled only in IDLE.
- angle  in  DATA_WIDTH  signed Q2.30 radians; intended range [-pi/2, +pi/2].
- sine_cosine_sel  in  1  selects the result: 0 = sine, 1 = cosine. Captured with the start.
- sine_cosine_value  out  DATA_WIDTH  signed Q2.30 result; held until the next result.
- value_valid  out  1  one-cycle pulse when sine_cosine_value updates.
- busy  out  1  high from the cycle after the accepted start until the cycle value_valid is asserted (inclusive).

## Operation
- States: IDLE, ITERATE, DONE.
- IDLE, with sin_calc_start=1:
  - Clamp angle to ±pi/2 (0x6487ED51 / -0x6487ED51).
  - Load x=K=0x26DD3B6A (0.6072529 in Q2.30), y=0, z=clamped angle, i=0.
  - Capture sine_cosine_sel.
  - Go to ITERATE.
- IDLE, with sin_calc_start=0: remain in IDLE; registers hold.
- ITERATE, each cycle:
  - d=+1 if z>=0, else d=-1.
  - x' = x - d·(y>>>i); y' = y + d·(x>>>i); z' = z - d·atan_lut[i].
  - Shifts are arithmetic. Adds/subtracts are 32-bit two's complement; intermediates cannot overflow in this range.
  - i increments. When i = ITERATIONS-1 is processed, go to DONE.
- atan_lut[i] = atan(2^-i) in Q2.30, rounded to nearest. Entry 0 is 0x3243F6A9. The table is an internal constant ROM of 30 entries.
- DONE:
  - Result = y (sine) or x (cosine), saturated to [-0x40000000, +0x40000000].
  - Register the result into sine_cosine_value.
  - Pulse value_valid, then return to IDLE.
- sin_calc_start while busy (ITERATE or DONE): ignored. No queuing, no error flag.
- angle and sine_cosine_sel are don't-care except in the start cycle.

## Timing
- Start accepted at rising edge E0.
- ITERATE occupies edges E1..E(ITERATIONS).
- DONE is processed at edge E(ITERATIONS+1). sine_cosine_value and value_valid are visible after that edge.
- Latency = ITERATIONS+1 cycles (25 at default).
- value_valid is high for exactly one cycle. sine_cosine_value is stable from that cycle until the next DONE.
- Back-to-back operation: a start asserted in the cycle after value_valid is accepted (state is IDLE then). Minimum start-to-start spacing is ITERATIONS+2 cycles.
- Reset has priority over all other inputs, including a coincident start. Reset in any state gives the following values after the edge:
  - state=IDLE; x, y, z, i cleared.
  - sine_cosine_value=0, value_valid=0, busy=0.
  - An in-flight computation is discarded, with no partial result or pulse.
- Reset asserted in the same cycle as DONE suppresses the value_valid pulse.

## Test plan
- Reset, then hold idle -> sine_cosine_value=0, value_valid=0, busy=0. Start held high together with reset -> still idle after reset deasserts.
- angle=0, sel=1 -> after 25 cycles: value_valid pulses once; value = 0x40000000 ±128 LSB; busy high for the preceding 25 cycles.
- angle=pi/6 (0x2182A471), sel=0 -> 0x20000000 ±128 LSB. Same angle with sel=1 -> 0x376CF5D1 ±128 LSB.
- angle=-pi/2 (0x9B7812AF), sel=0 -> -0x40000000 ±128 LSB, never below -0x40000000 (saturation). angle=0x7FFFFFFF, sel=1 -> clamped to pi/2; result |value| ≤ 128.
- Start pulsed repeatedly during ITERATE -> exactly one value_valid, for the first request only. Start in the cycle after value_valid -> second result after 25 more cycles.
- Reset asserted at iteration 10 -> no value_valid; outputs zero; a new start after reset gives the correct full-latency result.

Source files
------------

// File: rtl/sin_cos_cordic.sv
// rtl/sin_cos_cordic.sv - iterative CORDIC sine/cosine engine, one micro-rotation per clock.
// Signed Q2.30 angle in, signed Q2.30 sine or cosine out with a done pulse.
module sin_cos_cordic #(
  parameter int DATA_WIDTH  = 32,
  parameter int ITERATIONS  = 24,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sin_calc_start,
  input  logic [DATA_WIDTH-1:0] angle,
  input  logic                  sine_cosine_sel,
  output logic [DATA_WIDTH-1:0] sine_cosine_value,
  output logic                  value_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITERATE,
    ST_DONE
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0] HALF_PI  = 32'sh6487ED51;
  localparam logic signed [DATA_WIDTH-1:0] CORDIC_K = 32'sh26DD3B6A;
  localparam logic signed [DATA_WIDTH-1:0] ONE      = 32'sh40000000;
  localparam logic [COUNT_WIDTH-1:0]       LAST_ITER = COUNT_WIDTH'(ITERATIONS - 1);

  // atan(2^-i) in Q2.30, rounded to nearest
  localparam logic signed [DATA_WIDTH-1:0] ATAN_LUT [30] = '{
    32'sh3243F6A9, 32'sh1DAC6705, 32'sh0FADBAFD, 32'sh07F56EA7,
    32'sh03FEAB77, 32'sh01FFD55C, 32'sh00FFFAAB, 32'sh007FFF55,
    32'sh003FFFEB, 32'sh001FFFFD, 32'sh00100000, 32'sh00080000,
    32'sh00040000, 32'sh00020000, 32'sh00010000, 32'sh00008000,
    32'sh00004000, 32'sh00002000, 32'sh00001000, 32'sh00000800,
    32'sh00000400, 32'sh00000200, 32'sh00000100, 32'sh00000080,
    32'sh00000040, 32'sh00000020, 32'sh00000010, 32'sh00000008,
    32'sh00000004, 32'sh00000002
  };

  state_t                         r_state;
  state_t                         w_next_state;
  logic signed [DATA_WIDTH-1:0]   r_x;
  logic signed [DATA_WIDTH-1:0]   r_y;
  logic signed [DATA_WIDTH-1:0]   r_z;
  logic [COUNT_WIDTH-1:0]         r_i;
  logic                           r_sel;
  logic [DATA_WIDTH-1:0]          r_value;
  logic                           r_valid;

  logic signed [DATA_WIDTH-1:0]   w_angle;
  logic signed [DATA_WIDTH-1:0]   w_angle_clamped;
  logic signed [DATA_WIDTH-1:0]   w_x_shift;
  logic signed [DATA_WIDTH-1:0]   w_y_shift;
  logic signed [DATA_WIDTH-1:0]   w_atan;
  logic                           w_rotate_pos;
  logic signed [DATA_WIDTH-1:0]   w_raw_result;
  logic signed [DATA_WIDTH-1:0]   w_sat_result;

  assign w_angle = $signed(angle);
  assign w_angle_clamped = (w_angle > HALF_PI)  ? HALF_PI  :
                           (w_angle < -HALF_PI) ? -HALF_PI : w_angle;

  assign w_x_shift    = r_x >>> r_i;
  assign w_y_shift    = r_y >>> r_i;
  assign w_atan       = ATAN_LUT[r_i];
  assign w_rotate_pos = ~r_z[DATA_WIDTH-1];

  // CORDIC gain error can push the magnitude slightly past 1.0
  assign w_raw_result = r_sel ? r_x : r_y;
  assign w_sat_result = (w_raw_result > ONE)  ? ONE  :
                        (w_raw_result < -ONE) ? -ONE : w_raw_result;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (sin_calc_start) w_next_state = ST_ITERATE;
      ST_ITERATE: if (r_i == LAST_ITER) w_next_state = ST_DONE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_sel   <= 1'b0;
      r_value <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sin_calc_start) begin
            r_x   <= CORDIC_K;
            r_y   <= '0;
            r_z   <= w_angle_clamped;
            r_i   <= '0;
            r_sel <= sine_cosine_sel;
          end
        end
        ST_ITERATE: begin
          if (w_rotate_pos) begin
            r_x <= r_x - w_y_shift;
            r_y <= r_y + w_x_shift;
            r_z <= r_z - w_atan;
          end else begin
            r_x <= r_x + w_y_shift;
            r_y <= r_y - w_x_shift;
            r_z <= r_z + w_atan;
          end
          r_i <= r_i + 1'b1;
        end
        ST_DONE: begin
          r_value <= w_sat_result;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sine_cosine_value = r_value;
  assign value_valid       = r_valid;
  // The done-pulse cycle still counts as busy
  assign busy              = (r_state != ST_IDLE) | r_valid;

endmodule

// File: tb/tb_sin_cos_cordic.sv
// tb/tb_sin_cos_cordic.sv - randomized self-checking bench for sin_cos_cordic.
// Results are compared against real-valued sin/cos of the clamped angle.
module tb_sin_cos_cordic;

  localparam longint ONE_Q30  = 64'sd1073741824;
  localparam longint HALF_PI  = 64'sd1686629713;
  localparam int     LATENCY  = 25;

  logic        clock;
  logic        reset;
  logic        sin_calc_start;
  logic [31:0] angle;
  logic        sine_cosine_sel;
  logic [31:0] sine_cosine_value;
  logic        value_valid;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  sin_cos_cordic dut (
    .clock             (clock),
    .reset             (reset),
    .sin_calc_start    (sin_calc_start),
    .angle             (angle),
    .sine_cosine_sel   (sine_cosine_sel),
    .sine_cosine_value (sine_cosine_value),
    .value_valid       (value_valid),
    .busy              (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    n_checks++;
    if ((obs - exp > tol) || (exp - obs > tol))
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    else
      n_pass++;
  endtask

  function automatic longint ref_val(input logic [31:0] ang, input logic sel);
    longint a_q;
    real    a;
    real    r;
    longint q;
    a_q = longint'($signed(ang));
    if (a_q > HALF_PI) a_q = HALF_PI;
    if (a_q < -HALF_PI) a_q = -HALF_PI;
    a = $itor(a_q) / 1073741824.0;
    r = sel ? $cos(a) : $sin(a);
    r = r * 1073741824.0;
    q = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
    if (q > ONE_Q30) q = ONE_Q30;
    if (q < -ONE_Q30) q = -ONE_Q30;
    return q;
  endfunction

  // Called at a negedge; returns at the negedge just after the start was sampled.
  task automatic start_op(input logic [31:0] ang, input logic sel);
    sin_calc_start  = 1'b1;
    angle           = ang;
    sine_cosine_sel = sel;
    @(negedge clock);
    sin_calc_start  = 1'b0;
    angle           = $urandom;
    sine_cosine_sel = 1'($urandom);
  endtask

  task automatic collect(input bit poke, input int tail, output longint val, output int lat,
                         output int pulses, output int busy_cnt, output int vv_busy);
    int found_c;
    found_c  = 0;
    val      = 0;
    pulses   = 0;
    busy_cnt = 0;
    vv_busy  = 0;
    for (int c = 1; c <= 60; c++) begin
      if (value_valid) begin
        pulses++;
        if (found_c == 0) begin
          found_c = c;
          val     = longint'($signed(sine_cosine_value));
          vv_busy = int'(busy);
        end
      end else if (busy && found_c == 0) begin
        busy_cnt++;
      end
      if (found_c != 0 && c >= found_c + tail) break;
      if (poke) begin
        sin_calc_start = (c >= 2 && c <= 22) ? 1'(c) : 1'b0;
        angle          = $urandom;
      end
      @(negedge clock);
    end
    sin_calc_start = 1'b0;
    lat = (found_c == 0) ? -1 : found_c - 1;
  endtask

  task automatic run_named(input string tag, input logic [31:0] ang, input logic sel,
                           input longint exp, input longint tol, output longint val);
    int lat, pulses, busy_cnt, vv_busy;
    start_op(ang, sel);
    collect(1'b0, 3, val, lat, pulses, busy_cnt, vv_busy);
    check({tag, "_value"}, val, exp, tol);
    check({tag, "_latency"}, lat, LATENCY, 0);
    check({tag, "_pulses"}, pulses, 1, 0);
    check({tag, "_busy_cycles"}, busy_cnt, LATENCY, 0);
    check({tag, "_busy_at_valid"}, vv_busy, 1, 0);
  endtask

  initial begin
    longint     val;
    longint     val2;
    int         lat, pulses, busy_cnt, vv_busy;
    int         vv_seen;
    logic [31:0] ang;
    logic        sel;

    reset           = 1'b1;
    sin_calc_start  = 1'b1;
    angle           = 32'h2182A471;
    sine_cosine_sel = 1'b0;
    repeat (3) @(negedge clock);
    reset          = 1'b0;
    sin_calc_start = 1'b0;
    @(negedge clock);
    check("reset_value", longint'(sine_cosine_value), 0, 0);
    check("reset_valid", longint'(value_valid), 0, 0);
    check("reset_busy_start_held", longint'(busy), 0, 0);
    repeat (3) @(negedge clock);
    check("idle_busy", longint'(busy), 0, 0);

    run_named("cos0", 32'h00000000, 1'b1, ONE_Q30, 128, val);
    run_named("sin30", 32'h2182A471, 1'b0, 64'sd536870912, 128, val);
    run_named("cos30", 32'h2182A471, 1'b1, 64'sd929887697, 128, val);
    run_named("sin_neg90", 32'h9B7812AF, 1'b0, -ONE_Q30, 128, val);
    check("sin_neg90_sat", longint'(val < -ONE_Q30), 0, 0);
    run_named("cos_clamp", 32'h7FFFFFFF, 1'b1, 0, 128, val);

    // Starts pulsed during ITERATE must be ignored
    ang = 32'($urandom_range(32'h6487ED51)) - 32'h3243F6A8;
    sel = 1'($urandom);
    start_op(ang, sel);
    collect(1'b1, 15, val, lat, pulses, busy_cnt, vv_busy);
    check("poke_pulses", pulses, 1, 0);
    check("poke_value", val, ref_val(ang, sel), 300);
    check("poke_latency", lat, LATENCY, 0);

    // Back-to-back: second start asserted during the value_valid cycle
    start_op(32'h10000000, 1'b0);
    collect(1'b0, 0, val, lat, pulses, busy_cnt, vv_busy);
    check("b2b_first", val, ref_val(32'h10000000, 1'b0), 300);
    start_op(32'hE0000000, 1'b1);
    collect(1'b0, 2, val2, lat, pulses, busy_cnt, vv_busy);
    check("b2b_second_latency", lat, LATENCY, 0);
    check("b2b_second_value", val2, ref_val(32'hE0000000, 1'b1), 300);

    // Reset mid-computation discards it
    start_op(32'h20000000, 1'b0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_value", longint'(sine_cosine_value), 0, 0);
    check("midreset_busy", longint'(busy), 0, 0);
    vv_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (value_valid) vv_seen++;
      @(negedge clock);
    end
    check("midreset_no_valid", vv_seen, 0, 0);
    run_named("after_reset", 32'h2182A471, 1'b0, 64'sd536870912, 128, val);

    // Reset coinciding with the DONE edge suppresses the pulse
    start_op(32'h30000000, 1'b1);
    repeat (LATENCY - 1) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("done_reset_valid", longint'(value_valid), 0, 0);
    check("done_reset_value", longint'(sine_cosine_value), 0, 0);
    vv_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (value_valid) vv_seen++;
      @(negedge clock);
    end
    check("done_reset_no_valid", vv_seen, 0, 0);

    for (int n = 0; n < 24; n++) begin
      ang = (n < 16) ? 32'($urandom_range(32'hC90FDAA2)) - 32'h6487ED51 : 32'($urandom);
      sel = 1'($urandom);
      start_op(ang, sel);
      collect(1'b0, 0, val, lat, pulses, busy_cnt, vv_busy);
      check($sformatf("rand%0d_value", n), val, ref_val(ang, sel), 300);
      check($sformatf("rand%0d_latency", n), lat, LATENCY, 0);
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
